// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: operand/result handshake bundle for the sequential binary-to-BCD converter.
interface bin2bcd_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [3:0] hund;
  logic       ovf;
  modport master (output in_valid, in, out_ready, input in_ready, out_valid, out, hund, ovf);
  modport slave  (input in_valid, in, out_ready, output in_ready, out_valid, out, hund, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 8-bit binary to 3-digit BCD via 8-step double dabble; optional macro BIN2BCD_CLAMP_EN
// saturates results >= 100 to out=8'h99, hund=0 so the 8-bit bus never carries a truncated value.
module bin2bcd_seq (
  input logic          clk,
  input logic          rst,
  bin2bcd_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      st;
  logic [7:0]  bin;
  logic [11:0] acc;
  logic [2:0]  cnt;
  logic [11:0] adj;
  logic [19:0] sh;
  always_comb begin
    adj = acc;
    for (int i = 0; i < 3; i++)
      adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    sh = {adj, bin} << 1;
  end
  assign bus.in_ready = (st == IDLE) & ~rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      bin           <= '0;
      acc           <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.hund      <= '0;
      bus.ovf       <= 1'b0;
    end else begin
      case (st)
        IDLE: if (bus.in_valid) begin
          bin <= bus.in;
          acc <= '0;
          cnt <= '0;
          st  <= SHIFT;
        end
        SHIFT: begin
          {acc, bin} <= sh;
          cnt        <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            st            <= DONE;
            bus.out_valid <= 1'b1;
            bus.ovf       <= sh[19:16] != 4'd0;
`ifdef BIN2BCD_CLAMP_EN
            bus.out       <= sh[19:16] != 4'd0 ? 8'h99 : sh[15:8];
            bus.hund      <= 4'd0;
`else
            bus.out       <= sh[15:8];
            bus.hund      <= sh[19:16];
`endif
          end
        end
        DONE: if (bus.out_ready) begin
          st            <= IDLE;
          bus.out_valid <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and swept checks of bin2bcd_seq handshake, latency, reset and digit values.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bin2bcd_seq_if bus ();
  bin2bcd_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic logic [12:0] model(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
`ifdef BIN2BCD_CLAMP_EN
    return v >= 100 ? {4'd0, 8'h99, 1'b1} : {h, t, o, 1'b0};
`else
    return {h, t, o, v >= 100};
`endif
  endfunction
  task automatic convert(input logic [7:0] v, output logic [12:0] res, output int lat,
                         output logic rdy_after, output logic vld_after);
    bus.in_valid  = 1'b1;
    bus.in        = v;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) break;
    end
    res = {bus.hund, bus.out, bus.ovf};
    @(posedge clk); #1;
    rdy_after = bus.in_ready;
    vld_after = bus.out_valid;
  endtask
  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.in        = 8'd77;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.hund, bus.out, bus.ovf} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b hund=%h out=%h ovf=%b, want all 0",
               bus.in_ready, bus.out_valid, bus.hund, bus.out, bus.ovf);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    end
  endtask
  task automatic test_zero();
    logic [12:0] r; int lat; logic ra, va;
    convert(8'd0, r, lat, ra, va);
    n_cmp++;
    if (lat !== 8) begin n_bad++; $display("FAIL zero_latency: got %0d want 8", lat); end
    n_cmp++;
    if (r !== 13'h0000) begin n_bad++; $display("FAIL zero_result: got %h want 0000", r); end
    n_cmp++;
    if ({ra, va} !== 2'b10) begin
      n_bad++;
      $display("FAIL zero_release: got rdy=%b vld=%b want rdy=1 vld=0", ra, va);
    end
  endtask
  task automatic test_back_to_back();
    logic [12:0] r; int lat; logic ra, va;
    convert(8'd99, r, lat, ra, va);
    n_cmp++;
    if ({r, 5'(lat)} !== {4'd0, 8'h99, 1'b0, 5'd8}) begin
      n_bad++;
      $display("FAIL b2b_99: got res=%h lat=%0d want hund=0 out=99 ovf=0 lat=8", r, lat);
    end
    convert(8'd45, r, lat, ra, va);
    n_cmp++;
    if ({r, 5'(lat)} !== {4'd0, 8'h45, 1'b0, 5'd8}) begin
      n_bad++;
      $display("FAIL b2b_45: got res=%h lat=%0d want hund=0 out=45 ovf=0 lat=8", r, lat);
    end
  endtask
  task automatic test_reset_mid();
    logic [12:0] r; int lat; logic ra, va;
    bus.in_valid  = 1'b1;
    bus.in        = 8'd200;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out} !== 10'd0) begin
      n_bad++;
      $display("FAIL midshift_reset: got rdy=%b vld=%b out=%h want 0/0/00",
               bus.in_ready, bus.out_valid, bus.out);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL midshift_idle: in_ready=%b want 1", bus.in_ready); end
    convert(8'd7, r, lat, ra, va);
    n_cmp++;
    if (r !== {4'd0, 8'h07, 1'b0}) begin n_bad++; $display("FAIL after_reset_7: got %h want 0000e", r); end
  endtask
  task automatic test_max();
    logic [12:0] r; int lat; logic ra, va;
    convert(8'd255, r, lat, ra, va);
    n_cmp++;
`ifdef BIN2BCD_CLAMP_EN
    if (r !== {4'd0, 8'h99, 1'b1}) begin n_bad++; $display("FAIL max_255: got %h want hund=0 out=99 ovf=1", r); end
`else
    if (r !== {4'd2, 8'h55, 1'b1}) begin n_bad++; $display("FAIL max_255: got %h want hund=2 out=55 ovf=1", r); end
`endif
  endtask
  task automatic test_stall();
    logic [12:0] exp, snap;
`ifdef BIN2BCD_CLAMP_EN
    exp = {4'd0, 8'h99, 1'b1};
`else
    exp = {4'd1, 8'h00, 1'b1};
`endif
    bus.in_valid  = 1'b1;
    bus.in        = 8'd100;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    snap = {bus.hund, bus.out, bus.ovf};
    n_cmp++;
    if ({bus.out_valid, snap} !== {1'b1, exp}) begin
      n_bad++;
      $display("FAIL stall_result: got vld=%b res=%h want vld=1 res=%h", bus.out_valid, snap, exp);
    end
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in       = 8'd55;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.hund, bus.out, bus.ovf} !== {2'b10, exp}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got vld=%b rdy=%b res=%h want vld=1 rdy=0 res=%h",
                 k, bus.out_valid, bus.in_ready, {bus.hund, bus.out, bus.ovf}, exp);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL stall_release: got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    repeat (9) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL stall_not_consumed: got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask
  task automatic test_sweep();
    logic [12:0] got;
    logic        done;
    for (int v = 0; v < 256; v++) begin
      bus.in_valid  = 1'b1;
      bus.in        = 8'(v);
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      done = 1'b0;
      got  = '1;
      for (int k = 0; k < 40 && !done; k++) begin
        bus.out_ready = $urandom_range(0, 2) != 0;
        if (bus.out_valid && bus.out_ready) begin
          got  = {bus.hund, bus.out, bus.ovf};
          done = 1'b1;
        end
        @(posedge clk); #1;
      end
      n_cmp++;
      if (!done || got !== model(v)) begin
        n_bad++;
        $display("FAIL sweep_%0d: got %h done=%b want %h", v, got, done, model(v));
      end
      n_cmp++;
      if (got[12:9] > 4'd2 || got[8:5] > 4'd9 || got[4:1] > 4'd9) begin
        n_bad++;
        $display("FAIL sweep_digits_%0d: got hund=%h out=%h want digits <= 9", v, got[12:9], got[8:1]);
      end
    end
    bus.out_ready = 1'b1;
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_max();
    test_stall();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
